// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table,
// segment bit positions and a nibble-to-glyph lookup.
package sseg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // All seven segment bits set; XOR with this flips glyph polarity.
  localparam logic [6:0] SEG_ALL = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) |
                                      (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) |
                                      (1 << SEG_G));

  // Active-high glyphs, bit0 = a ... bit6 = g.
  localparam logic [6:0] GLYPHS [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    return GLYPHS[nib];
  endfunction

endpackage

// File: rtl/sseg_decode.sv
// Nibble to segment pattern for one digit, with blanking and pin polarity.
module sseg_decode
  import sseg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input  logic [3:0] i_nibble,
  input  logic       i_blank,
  input  logic       i_dp,
  output logic [6:0] o_seg,
  output logic       o_dp
);

  logic [6:0] w_seg_hi;

  // A blanked digit lights nothing; otherwise look up the hex glyph.
  assign w_seg_hi = i_blank ? 7'h00 : hex_glyph(i_nibble);
  assign o_seg    = SEG_ACTIVE_LOW ? (w_seg_hi ^ SEG_ALL) : w_seg_hi;
  assign o_dp     = SEG_ACTIVE_LOW ? ~i_dp : i_dp;

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed N-digit seven-segment driver. A shadow register takes loads at
// any time; the scanned display copy is only refreshed at the frame boundary
// so a frame never shows a mix of old and new digits.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SLOT_CYCLES    = 100000,
  parameter int GUARD_CYCLES   = 1,
  parameter bit SEG_ACTIVE_LOW = 1,
  parameter bit AN_ACTIVE_LOW  = 1,
  parameter bit BLANK_LEADING  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*N_DIGITS-1:0] i_value,
  input  logic [N_DIGITS-1:0]   i_dp,
  input  logic                  i_load,
  output logic [6:0]            o_sseg,
  output logic                  o_dp,
  output logic [N_DIGITS-1:0]   o_an,
  output logic                  o_pending,
  output logic                  o_frame
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [CNT_W:0]      GUARD_L = (CNT_W + 1)'(GUARD_CYCLES);

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*N_DIGITS-1:0] r_shadow_val;
  logic [N_DIGITS-1:0]   r_shadow_dp;
  logic [4*N_DIGITS-1:0] r_disp_val;
  logic [N_DIGITS-1:0]   r_disp_dp;
  logic                  r_pending;
  logic [6:0]            r_sseg;
  logic                  r_dp;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_frame;

  logic                  w_slot_end;
  logic                  w_last_digit;
  logic                  w_boundary;
  logic                  w_guard;
  logic [N_DIGITS-1:0]   w_blank;
  logic                  w_lead;
  logic [3:0]            w_nib;
  logic                  w_sel_dp;
  logic                  w_sel_blank;
  logic [N_DIGITS-1:0]   w_onehot;
  logic [6:0]            w_dec_seg;
  logic                  w_dec_dp;

  assign w_slot_end   = (r_cnt == CNT_W'(SLOT_CYCLES - 1));
  assign w_last_digit = (r_idx == IDX_W'(N_DIGITS - 1));
  assign w_boundary   = w_slot_end && w_last_digit;
  assign w_guard      = ({1'b0, r_cnt} < GUARD_L);

  // Slot counter and digit index; the index advances on every slot wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= w_last_digit ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Shadow capture and frame-boundary transfer into the display copy. A load
  // on the boundary itself bypasses the shadow so it is not delayed a frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_pending    <= 1'b0;
    end else begin
      if (i_load) begin
        r_shadow_val <= i_value;
        r_shadow_dp  <= i_dp;
      end
      if (w_boundary) begin
        r_pending <= 1'b0;
        if (i_load) begin
          r_disp_val <= i_value;
          r_disp_dp  <= i_dp;
        end else if (r_pending) begin
          r_disp_val <= r_shadow_val;
          r_disp_dp  <= r_shadow_dp;
        end
      end else if (i_load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Leading-zero mask, walking from the most significant digit down to 1.
  always_comb begin
    w_blank = '0;
    w_lead  = BLANK_LEADING;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if (w_lead && (r_disp_val[k*4 +: 4] == 4'h0) && !r_disp_dp[k]) begin
        w_blank[k] = 1'b1;
      end else begin
        w_lead = 1'b0;
      end
    end
  end

  // Pick the nibble, dp and blank bit of the digit currently being scanned.
  always_comb begin
    w_nib       = 4'h0;
    w_sel_dp    = 1'b0;
    w_sel_blank = 1'b0;
    w_onehot    = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nib       = r_disp_val[k*4 +: 4];
        w_sel_dp    = r_disp_dp[k];
        w_sel_blank = w_blank[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

  sseg_decode #(
    .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
  ) u_decode (
    .i_nibble(w_nib),
    .i_blank (w_sel_blank),
    .i_dp    (w_sel_dp),
    .o_seg   (w_dec_seg),
    .o_dp    (w_dec_dp)
  );

  // Registered pins; anodes stay off during the guard window of each slot.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sseg  <= SEG_OFF;
      r_dp    <= DP_OFF;
      r_an    <= AN_OFF;
      r_frame <= 1'b0;
    end else begin
      r_sseg  <= w_dec_seg;
      r_dp    <= w_dec_dp;
      r_an    <= w_guard ? AN_OFF : (AN_ACTIVE_LOW ? ~w_onehot : w_onehot);
      r_frame <= w_boundary;
    end
  end

  assign o_sseg    = r_sseg;
  assign o_dp      = r_dp;
  assign o_an      = r_an;
  assign o_pending = r_pending;
  assign o_frame   = r_frame;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Directed bench for sseg_scan_driver: 4 digits, 8-cycle slots, 1 guard cycle,
// active-low segments and anodes, leading-zero blanking on.
module tb_sseg_scan_driver;

  logic        clk     = 1'b0;
  logic        i_rst   = 1'b1;
  logic [15:0] i_value = 16'h0;
  logic [3:0]  i_dp    = 4'h0;
  logic        i_load  = 1'b0;
  logic [6:0]  o_sseg;
  logic        o_dp;
  logic [3:0]  o_an;
  logic        o_pending;
  logic        o_frame;

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] an_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  sseg_scan_driver #(
    .N_DIGITS      (4),
    .SLOT_CYCLES   (8),
    .GUARD_CYCLES  (1),
    .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW (1),
    .BLANK_LEADING (1)
  ) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_value  (i_value),
    .i_dp     (i_dp),
    .i_load   (i_load),
    .o_sseg   (o_sseg),
    .o_dp     (o_dp),
    .o_an     (o_an),
    .o_pending(o_pending),
    .o_frame  (o_frame)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    i_value = v;
    i_dp    = d;
    i_load  = 1'b1;
    @(negedge clk);
    i_load  = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    bit got = 1'b0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (o_frame) got = 1'b1;
    end
    n_total++;
    if (!got) $display("FAIL %s_frame_timeout: no o_frame within 100 cycles, required a pulse", tag);
    else n_pass++;
  endtask

  // Called at the negedge where o_frame is high; walks the whole next frame.
  // segs holds {d3,d2,d1,d0} pin patterns, dpn the per-digit dp pin levels.
  task automatic scan_frame(input logic [27:0] segs, input logic [3:0] dpn, input string tag);
    logic [6:0] es;
    for (int k = 0; k < 4; k++) begin
      es = segs[k*7 +: 7];
      @(negedge clk);
      n_total++;
      if (o_an !== 4'hF) $display("FAIL %s_guard_an d%0d: got %b want 1111", tag, k, o_an);
      else n_pass++;
      n_total++;
      if (o_sseg !== es) $display("FAIL %s_guard_seg d%0d: got %h want %h", tag, k, o_sseg, es);
      else n_pass++;
      n_total++;
      if (o_frame !== 1'b0) $display("FAIL %s_frame_mid d%0d: got %b want 0", tag, k, o_frame);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (o_an !== an_exp[k]) $display("FAIL %s_an d%0d: got %b want %b", tag, k, o_an, an_exp[k]);
      else n_pass++;
      n_total++;
      if (o_sseg !== es) $display("FAIL %s_seg d%0d: got %h want %h", tag, k, o_sseg, es);
      else n_pass++;
      n_total++;
      if (o_dp !== dpn[k]) $display("FAIL %s_dp d%0d: got %b want %b", tag, k, o_dp, dpn[k]);
      else n_pass++;
      tick(6);
    end
    n_total++;
    if (o_frame !== 1'b1) $display("FAIL %s_frame_period: got %b want 1 after 32 cycles", tag, o_frame);
    else n_pass++;
  endtask

  // Checks the first frame after a reset release; called on the release cycle.
  task automatic check_after_release(input string tag);
    int first = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (o_frame && first < 0) first = n;
      if (n == 1) begin
        n_total++;
        if (o_an !== 4'hF) $display("FAIL %s_first_guard_an: got %b want 1111", tag, o_an);
        else n_pass++;
      end
      if (n == 2) begin
        n_total++;
        if (o_an !== 4'b1110) $display("FAIL %s_first_an: got %b want 1110", tag, o_an);
        else n_pass++;
        n_total++;
        if (o_sseg !== 7'h40) $display("FAIL %s_first_seg: got %h want 40", tag, o_sseg);
        else n_pass++;
        n_total++;
        if (o_pending !== 1'b0) $display("FAIL %s_first_pending: got %b want 0", tag, o_pending);
        else n_pass++;
      end
      if (n == 10) begin
        n_total++;
        if (o_an !== 4'b1101) $display("FAIL %s_d1_an: got %b want 1101", tag, o_an);
        else n_pass++;
        n_total++;
        if (o_sseg !== 7'h7F) $display("FAIL %s_d1_blank: got %h want 7f", tag, o_sseg);
        else n_pass++;
      end
    end
    n_total++;
    if (first != 32) $display("FAIL %s_first_frame: got cycle %0d want 32", tag, first);
    else n_pass++;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (o_an !== 4'hF) $display("FAIL reset_an: got %b want 1111", o_an);
    else n_pass++;
    n_total++;
    if (o_sseg !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", o_sseg);
    else n_pass++;
    n_total++;
    if (o_dp !== 1'b1) $display("FAIL reset_dp: got %b want 1", o_dp);
    else n_pass++;
    n_total++;
    if (o_pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", o_pending);
    else n_pass++;
    n_total++;
    if (o_frame !== 1'b0) $display("FAIL reset_frame: got %b want 0", o_frame);
    else n_pass++;
    i_rst = 1'b0;
    check_after_release("reset");
    wait_frame("reset_sync");
  endtask

  task automatic test_load_frame(input logic [15:0] v, input logic [3:0] d,
                                 input logic [27:0] segs, input logic [3:0] dpn, input string tag);
    load(v, d);
    n_total++;
    if (o_pending !== 1'b1) $display("FAIL %s_pending_rise: got %b want 1", tag, o_pending);
    else n_pass++;
    wait_frame(tag);
    n_total++;
    if (o_pending !== 1'b0) $display("FAIL %s_pending_fall: got %b want 0", tag, o_pending);
    else n_pass++;
    scan_frame(segs, dpn, tag);
  endtask

  // Display holds 0000 / dp 0100 on entry; the load lands in slot 1.
  task automatic test_mid_frame_load();
    tick(9);
    load(16'h12A0, 4'h0);
    n_total++;
    if (o_pending !== 1'b1) $display("FAIL mid_pending: got %b want 1", o_pending);
    else n_pass++;
    n_total++;
    if (o_an !== 4'b1101 || o_sseg !== 7'h40) $display("FAIL mid_d1_old: got an=%b seg=%h want an=1101 seg=40", o_an, o_sseg);
    else n_pass++;
    tick(8);
    n_total++;
    if (o_an !== 4'b1011 || o_sseg !== 7'h40 || o_dp !== 1'b0) $display("FAIL mid_d2_old: got an=%b seg=%h dp=%b want an=1011 seg=40 dp=0", o_an, o_sseg, o_dp);
    else n_pass++;
    wait_frame("mid");
    n_total++;
    if (o_pending !== 1'b0) $display("FAIL mid_pending_fall: got %b want 0", o_pending);
    else n_pass++;
    scan_frame({7'h79, 7'h24, 7'h08, 7'h40}, 4'hF, "mid");
  endtask

  task automatic test_boundary_load();
    tick(31);
    load(16'h0050, 4'h0);
    n_total++;
    if (o_frame !== 1'b1) $display("FAIL bnd_frame: got %b want 1", o_frame);
    else n_pass++;
    n_total++;
    if (o_pending !== 1'b0) $display("FAIL bnd_pending: got %b want 0", o_pending);
    else n_pass++;
    scan_frame({7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF, "bnd");
  endtask

  task automatic test_reset_mid();
    load(16'h1111, 4'h0);
    n_total++;
    if (o_pending !== 1'b1) $display("FAIL rstmid_pending_set: got %b want 1", o_pending);
    else n_pass++;
    tick(19);
    i_rst = 1'b1;
    @(negedge clk);
    n_total++;
    if (o_an !== 4'hF || o_sseg !== 7'h7F || o_dp !== 1'b1 || o_frame !== 1'b0)
      $display("FAIL rstmid_outputs: got an=%b seg=%h dp=%b frame=%b want an=1111 seg=7f dp=1 frame=0", o_an, o_sseg, o_dp, o_frame);
    else n_pass++;
    n_total++;
    if (o_pending !== 1'b0) $display("FAIL rstmid_pending: got %b want 0", o_pending);
    else n_pass++;
    i_rst = 1'b0;
    check_after_release("rstmid");
  endtask

  initial begin
    test_reset();
    test_load_frame(16'h12A0, 4'h0, {7'h79, 7'h24, 7'h08, 7'h40}, 4'hF, "hex12a0");
    test_load_frame(16'h0050, 4'h0, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF, "blank0050");
    test_load_frame(16'h0000, 4'b0100, {7'h7F, 7'h40, 7'h40, 7'h40}, 4'b1011, "blankdp");
    test_mid_frame_load();
    test_boundary_load();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
